// File: rtl/spike_raster_packer_if.sv
// spike_raster_packer_if: bundles the step-sampling inputs, the soft clear and the
// pipe-out endpoint signals of spike_raster_packer.
//   master: drives soft_clear, sample_en, spike_in, pipe_read; observes the rest.
//   slave : the packer itself.
// Signals:
//   soft_clear  synchronous level clear (pre-synchronised reset_sim)
//   sample_en   one-clk strobe per simulation step
//   spike_in    spike flag for the current step
//   pipe_read   endpoint read strobe (ep_read)
//   pipe_data   registered FIFO head word (ep_datain)
//   pipe_ready  at least one host block is buffered (ep_ready)
//   fifo_count  words currently buffered
//   overflow    sticky: a packed word was dropped
//   underflow   sticky: a read hit an empty FIFO
//   drop_cnt    saturating count of dropped words
interface spike_raster_packer_if #(
    parameter int unsigned DEPTH_LOG2 = 10
);
    logic                  soft_clear;
    logic                  sample_en;
    logic                  spike_in;
    logic                  pipe_read;
    logic [15:0]           pipe_data;
    logic                  pipe_ready;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overflow;
    logic                  underflow;
    logic [15:0]           drop_cnt;

    modport master (
        output soft_clear, sample_en, spike_in, pipe_read,
        input  pipe_data, pipe_ready, fifo_count, overflow, underflow, drop_cnt
    );

    modport slave (
        input  soft_clear, sample_en, spike_in, pipe_read,
        output pipe_data, pipe_ready, fifo_count, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/spike_raster_packer.sv
// spike_raster_packer: packs one spike bit per simulation step into 16-bit words
// (LSB = earliest step), buffers them in a circular FIFO and serves them to a
// block-throttled pipe-out endpoint.
// Ports:
//   clk           single clock for the whole block
//   reset_global  asynchronous, active-high reset
//   bus           spike_raster_packer_if.slave (sampling inputs, soft clear,
//                 pipe endpoint and status outputs)
module spike_raster_packer #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input logic                  clk,
    input logic                  reset_global,
    spike_raster_packer_if.slave bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    localparam logic [PW-1:0] FULL_CNT  = PW'(DEPTH);
    localparam logic [PW-1:0] READY_THR = PW'(BLOCK_WORDS);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    // Only bits 0..14 are stored; bit 15 is taken straight from spike_in on push.
    logic [14:0]   shift_q, shift_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [15:0]   data_q, data_d;
    logic          ready_q, ready_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [15:0]   drop_q, drop_d;

    logic [15:0]   mem [DEPTH];

    logic        push;
    logic        pop;
    logic        wr_en;
    logic        drop;
    logic        empty;
    logic        full;
    logic [15:0] word;

    assign push  = bus.sample_en && (bit_idx_q == 4'd15);
    assign word  = {bus.spike_in, shift_q};
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = bus.pipe_read && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        drop_d    = drop_q;

        if (bus.soft_clear) begin
            shift_d   = '0;
            bit_idx_d = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            data_d    = '0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
            drop_d    = '0;
        end else begin
            if (bus.sample_en) begin
                if (push) begin
                    shift_d   = '0;
                    bit_idx_d = '0;
                end else begin
                    shift_d[bit_idx_q] = bus.spike_in;
                    bit_idx_d          = bit_idx_q + 4'd1;
                end
            end

            if (pop) begin
                data_d = mem[rptr_q[DEPTH_LOG2-1:0]];
                rptr_d = rptr_q + PTR_ONE;
            end

            if (wr_en) begin
                wptr_d = wptr_q + PTR_ONE;
            end

            if (bus.pipe_read && empty) begin
                udf_d = 1'b1;
            end

            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end

        // Pointer MSB distinguishes full from empty, so the difference is the count.
        count_d = wptr_d - rptr_d;
        ready_d = (count_d >= READY_THR);
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            drop_q    <= drop_d;
        end
    end

    // Storage is not reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !bus.soft_clear) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= word;
        end
    end

    assign bus.pipe_data  = data_q;
    assign bus.pipe_ready = ready_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;
    assign bus.drop_cnt   = drop_q;

endmodule
